// File: rtl/sysid_regs_if.sv
// Avalon-MM slave bus bundle for the system ID register block.
interface sysid_regs_if;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_regs.sv
// System ID register block: constant ID/timestamp/user words, 64-bit uptime with
// high-word snapshot, and one byte-writable scratch register. Fixed 1-cycle read latency.
module sysid_regs #(
  parameter logic [31:0]  ID_VALUE   = 32'h58505350,
  parameter logic [31:0]  TIMESTAMP  = 32'h00000000,
  parameter int unsigned  USER_WORDS = 2,
  parameter logic [255:0] USER_DATA  = '0
) (
  input logic        clock,
  input logic        reset,
  sysid_regs_if.slave bus
);

  if (USER_WORDS > 8) begin : g_bad_user_words
    $error("sysid_regs: USER_WORDS must be in 0..8");
  end

  localparam logic [3:0] UserWordsNib = 4'(USER_WORDS);

  logic [63:0] r_uptime;
  logic [31:0] r_snap;
  logic [31:0] r_scratch;
  logic [31:0] r_rdata;
  logic        r_rvalid;

  logic [31:0] w_rdata;
  logic [31:0] w_user;
  logic [31:0] w_scratch_nx;
  logic        w_scratch_we;

  always_comb begin
    w_user = '0;
    if ({28'd0, bus.address[2:0]} < USER_WORDS) begin
      w_user = USER_DATA[{bus.address[2:0], 5'd0} +: 32];
    end
  end

  always_comb begin
    w_rdata = '0;
    if (bus.address[3]) begin
      w_rdata = w_user;
    end else begin
      case (bus.address[2:0])
        3'd0:    w_rdata = ID_VALUE;
        3'd1:    w_rdata = TIMESTAMP;
        3'd2:    w_rdata = r_uptime[31:0];
        3'd3:    w_rdata = r_snap;
        3'd4:    w_rdata = r_scratch;
        3'd5:    w_rdata = {28'd0, UserWordsNib};
        default: w_rdata = '0;
      endcase
    end
  end

  // A concurrent read wins: the write is dropped entirely.
  assign w_scratch_we = bus.write && !bus.read && (bus.address == 4'd4);

  always_comb begin
    w_scratch_nx = r_scratch;
    for (int k = 0; k < 4; k++) begin
      if (bus.byteenable[k]) begin
        w_scratch_nx[8*k +: 8] = bus.writedata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_uptime  <= '0;
      r_snap    <= '0;
      r_scratch <= '0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
    end else begin
      r_uptime <= r_uptime + 64'd1;
      r_rvalid <= bus.read;
      if (bus.read) begin
        r_rdata <= w_rdata;
        // Low-word read latches the matching high word for a coherent 64-bit pair.
        if (bus.address == 4'd2) begin
          r_snap <= r_uptime[63:32];
        end
      end
      if (w_scratch_we) begin
        r_scratch <= w_scratch_nx;
      end
    end
  end

  assign bus.readdata      = r_rdata;
  assign bus.readdatavalid = r_rvalid;

endmodule
